// File: rtl/sattn_pkg.sv
// sattn_pkg: accelerator register map, opcodes, scheduler states and the queued descriptor layout
package sattn_pkg;
  localparam logic [15:0] REG_M_ROWS   = 16'h0030;
  localparam logic [15:0] REG_HEAD_D   = 16'h0038;
  localparam logic [15:0] REG_S_TOKENS = 16'h0050;
  localparam logic [15:0] REG_CMD      = 16'h0060;
  localparam logic [15:0] REG_ACC_SUM  = 16'h0068;
  localparam logic [15:0] REG_SOF_SUM  = 16'h0080;
  localparam logic [15:0] REG_SPM_SUM  = 16'h0088;
  typedef enum logic [7:0] {
    CMD_NOP     = 8'h00,
    CMD_LOAD_Q  = 8'h10,
    CMD_LOAD_K  = 8'h11,
    CMD_LOAD_V  = 8'h12,
    CMD_MASK    = 8'h13,
    CMD_ACC     = 8'h14,
    CMD_SOFTMAX = 8'h15,
    CMD_SPMM    = 8'h16
  } cmd_e;
  typedef enum logic [2:0] {IDLE, WR_M, WR_D, WR_S, WR_CMD, POLL, RD_SUM, RESP} sched_state_e;
  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] m_rows;
    logic [15:0] head_d;
    logic [15:0] s_tokens;
    logic [3:0]  tag;
  } desc_t;
  // zero means the opcode has no checksum register
  function automatic logic [15:0] sum_addr(input logic [7:0] op);
    return op == CMD_ACC ? REG_ACC_SUM : op == CMD_SOFTMAX ? REG_SOF_SUM : op == CMD_SPMM ? REG_SPM_SUM : 16'h0;
  endfunction
endpackage

// File: rtl/sattn_cmd_fifo.sv
// sattn_cmd_fifo: synchronous descriptor FIFO with occupancy count; DEPTH must be a power of two
module sattn_cmd_fifo #(
  parameter int W = 60,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           din_i,
  output logic [W-1:0]           dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] count_q;
  logic wr, rd;
  assign count_o = count_q;
  assign full_o = count_q == (AW+1)'(DEPTH);
  assign empty_o = count_q == '0;
  assign wr = push_i && !full_o;
  assign rd = pop_i && !empty_o;
  assign dout_o = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_q] <= din_i;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(wr);
      rd_q <= rd_q + AW'(rd);
      count_q <= count_q + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/sattn_cmd_sched.sv
// sattn_cmd_sched: runs queued descriptors one at a time through shape/CMD writes, done polling and checksum read
// SATTN_SCHED_PERF_EN adds rsp_cycles, the saturating WR_M-to-RESP cycle count
module sattn_cmd_sched
  import sattn_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int QDEPTH = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_op,
  input  logic [15:0]             cmd_m_rows,
  input  logic [15:0]             cmd_head_d,
  input  logic [15:0]             cmd_s_tokens,
  input  logic [3:0]              cmd_tag,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [3:0]              rsp_tag,
  output logic [DATA_WIDTH-1:0]   rsp_sum,
  output logic                    rsp_err,
  output logic                    mmio_wen,
  output logic                    mmio_ren,
  output logic [ADDR_WIDTH-1:0]   mmio_addr,
  output logic [DATA_WIDTH-1:0]   mmio_wdata,
  input  logic [DATA_WIDTH-1:0]   mmio_rdata,
  output logic [$clog2(QDEPTH):0] q_count
`ifdef SATTN_SCHED_PERF_EN
  ,
  output logic [31:0]             rsp_cycles
`endif
);
  localparam int PW = $clog2(TIMEOUT_CYC + 1);
  desc_t din, dout, work_q, nxt;
  logic full, empty, pop;
  sched_state_e state_q, state_d;
  logic [PW-1:0] poll_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  assign din = {cmd_op, cmd_m_rows, cmd_head_d, cmd_s_tokens, cmd_tag};
  assign cmd_ready = !full;
  assign pop = state_q == IDLE && !empty;
  assign nxt = pop ? dout : work_q;
  sattn_cmd_fifo #(.W($bits(desc_t)), .DEPTH(QDEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(cmd_valid && !full),
    .pop_i(pop),
    .din_i(din),
    .dout_o(dout),
    .full_o(full),
    .empty_o(empty),
    .count_o(q_count)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = empty ? IDLE : dout.op == CMD_NOP ? RESP : WR_M;
      WR_M:    state_d = WR_D;
      WR_D:    state_d = WR_S;
      WR_S:    state_d = WR_CMD;
      WR_CMD:  state_d = POLL;
      POLL:    state_d = mmio_rdata[0] ? RD_SUM : poll_q == PW'(TIMEOUT_CYC - 1) ? RESP : POLL;
      RD_SUM:  state_d = RESP;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // strobes and address are registered from the next state so they line up with the state they belong to
  assign addr_d = state_d == WR_M ? ADDR_WIDTH'(REG_M_ROWS) :
                  state_d == WR_D ? ADDR_WIDTH'(REG_HEAD_D) :
                  state_d == WR_S ? ADDR_WIDTH'(REG_S_TOKENS) :
                  (state_d == WR_CMD || state_d == POLL) ? ADDR_WIDTH'(REG_CMD) :
                  state_d == RD_SUM ? ADDR_WIDTH'(sum_addr(nxt.op)) : '0;
  assign wdata_d = state_d == WR_M ? DATA_WIDTH'(nxt.m_rows) :
                   state_d == WR_D ? DATA_WIDTH'(nxt.head_d) :
                   state_d == WR_S ? DATA_WIDTH'(nxt.s_tokens) :
                   state_d == WR_CMD ? DATA_WIDTH'(nxt.op) : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q <= '0;
      poll_q <= '0;
      mmio_wen <= 1'b0;
      mmio_ren <= 1'b0;
      mmio_addr <= '0;
      mmio_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_tag <= '0;
      rsp_sum <= '0;
      rsp_err <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= nxt;
      poll_q <= state_q == POLL ? poll_q + 1'b1 : '0;
      mmio_wen <= state_d inside {WR_M, WR_D, WR_S, WR_CMD};
      mmio_ren <= state_d == POLL || (state_d == RD_SUM && sum_addr(nxt.op) != '0);
      mmio_addr <= addr_d;
      mmio_wdata <= wdata_d;
      rsp_valid <= state_d == RESP;
      rsp_tag <= state_d == RESP ? nxt.tag : '0;
      rsp_err <= state_d != RESP ? 1'b0 : state_q == RESP ? rsp_err : state_q == POLL;
      rsp_sum <= state_d != RESP ? '0 : state_q == RESP ? rsp_sum : state_q == RD_SUM && mmio_ren ? mmio_rdata : '0;
    end
  end
`ifdef SATTN_SCHED_PERF_EN
  logic [31:0] cyc_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cyc_q <= '0;
    else cyc_q <= pop ? '0 : (state_q == IDLE || state_q == RESP || &cyc_q) ? cyc_q : cyc_q + 1'b1;
  end
  assign rsp_cycles = rsp_valid ? cyc_q : '0;
`endif
endmodule

// File: tb/tb_sattn_cmd_sched.sv
// tb_sattn_cmd_sched: directed stimulus with a response scoreboard and a small MMIO register model
module tb_sattn_cmd_sched;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 1, rsp_err, mmio_wen, mmio_ren;
  logic [7:0] cmd_op = 0;
  logic [15:0] cmd_m_rows = 0, cmd_head_d = 0, cmd_s_tokens = 0, mmio_addr;
  logic [3:0] cmd_tag = 0, rsp_tag;
  logic [63:0] rsp_sum, mmio_wdata, mmio_rdata;
  logic [2:0] q_count;
`ifdef SATTN_SCHED_PERF_EN
  logic [31:0] rsp_cycles;
`endif
  typedef struct {logic [3:0] tag; logic [63:0] sum; logic err; int polls; int lat;} exp_t;
  typedef struct {int cyc; logic [15:0] addr; logic [63:0] data;} wr_t;
  exp_t sb[$];
  wr_t wlog[$];
  int checks = 0, failures = 0, cyc = 0, pc = 0, done_at = 10, cmd_cyc = 0, vcyc = 0;
  int rlog_n = 0, rd_cyc = 0, proto_bad = 0, hold_bad = 0;
  logic [15:0] rd_addr = 0;
  logic prev_v = 0, hold_mon = 0, snap_err = 0;
  logic [3:0] snap_tag = 0;
  logic [63:0] snap_sum = 0;
  logic [15:0] ea [4] = '{16'h30, 16'h38, 16'h50, 16'h60};
  logic [63:0] ed [4] = '{64'd4, 64'd8, 64'd16, 64'h14};

  sattn_cmd_sched dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_m_rows(cmd_m_rows), .cmd_head_d(cmd_head_d), .cmd_s_tokens(cmd_s_tokens), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_sum(rsp_sum), .rsp_err(rsp_err),
    .mmio_wen(mmio_wen), .mmio_ren(mmio_ren), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata),
    .mmio_rdata(mmio_rdata), .q_count(q_count)
`ifdef SATTN_SCHED_PERF_EN
    , .rsp_cycles(rsp_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // status register returns a one-cycle done pulse on the done_at-th poll after each CMD write
  always @(posedge clk or posedge rst)
    if (rst) pc <= 0;
    else if (mmio_wen && mmio_addr == 16'h60) pc <= 0;
    else if (mmio_ren && mmio_addr == 16'h60) pc <= pc + 1;

  always_comb begin
    mmio_rdata = '0;
    if (mmio_ren)
      case (mmio_addr)
        16'h60:  mmio_rdata = {63'd0, done_at != 0 && pc == done_at - 1};
        16'h68:  mmio_rdata = 64'h1234;
        16'h80:  mmio_rdata = 64'h0000_ABCD_0000_1111;
        16'h88:  mmio_rdata = 64'hDEAD_BEEF_0000_0042;
        default: mmio_rdata = 64'hBAD;
      endcase
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (mmio_wen && mmio_ren) proto_bad++;
    if (!mmio_wen && !mmio_ren && (mmio_addr != 0 || mmio_wdata != 0)) proto_bad++;
    if (mmio_wen) begin
      wlog.push_back('{cyc, mmio_addr, mmio_wdata});
      if (mmio_addr == 16'h60) cmd_cyc = cyc;
    end
    if (mmio_ren && mmio_addr != 16'h60) begin
      rlog_n++;
      rd_cyc = cyc;
      rd_addr = mmio_addr;
    end
    if (hold_mon && (!rsp_valid || rsp_tag !== snap_tag || rsp_sum !== snap_sum || rsp_err !== snap_err || mmio_wen || mmio_ren))
      hold_bad++;
    if (rsp_valid && !prev_v) vcyc = cyc;
    prev_v = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_extra: unexpected response tag %0d", rsp_tag);
      end else begin
        e = sb.pop_front();
        chk("rsp_tag", rsp_tag, e.tag);
        chk("rsp_sum", rsp_sum, e.sum);
        chk("rsp_err", rsp_err, e.err);
        if (e.polls >= 0) chk("rsp_polls", pc, e.polls);
        if (e.lat >= 0) chk("rsp_latency", vcyc - cmd_cyc, e.lat);
      end
    end
  end

  task automatic push(input logic [7:0] op, input logic [15:0] m, input logic [15:0] d, input logic [15:0] s,
                      input logic [3:0] tag, input logic [63:0] sum, input logic err, input int polls, input int lat);
    int n = 0;
    while (!cmd_ready && n < 10000) begin @(posedge clk); #1; n++; end
    chk("push_ready", cmd_ready, 1);
    cmd_valid = 1; cmd_op = op; cmd_m_rows = m; cmd_head_d = d; cmd_s_tokens = s; cmd_tag = tag;
    sb.push_back('{tag, sum, err, polls, lat});
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin @(posedge clk); #1; n++; end
    chk("drain_pending", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_strobes", {mmio_wen, mmio_ren}, 0);
    chk("reset_addr", mmio_addr, 0);
    chk("reset_q_count", q_count, 0);
    rst = 0;
    @(posedge clk); #1;

    // single checksum op, done on the 10th poll
    done_at = 10; wlog.delete(); rlog_n = 0;
    push(8'h14, 16'd4, 16'd8, 16'd16, 4'd3, 64'h1234, 1'b0, 10, 12);
    drain(200);
    chk("t1_write_count", wlog.size(), 4);
    if (wlog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t1_write_addr", wlog[i].addr, ea[i]);
        chk("t1_write_data", wlog[i].data, ed[i]);
        chk("t1_write_cycle", wlog[i].cyc - wlog[0].cyc, i);
      end
    chk("t1_read_count", rlog_n, 1);
    chk("t1_read_addr", rd_addr, 16'h68);
    if (wlog.size() == 4) chk("t1_read_cycle", rd_cyc - wlog[3].cyc, 11);

    // op without checksum register
    done_at = 3; rlog_n = 0;
    push(8'h12, 16'd1, 16'd2, 16'd3, 4'd4, 64'h0, 1'b0, 3, 5);
    drain(200);
    chk("t2_no_sum_read", rlog_n, 0);

    // opcode 0 bypasses the accelerator
    wlog.delete(); rlog_n = 0;
    push(8'h00, 16'd7, 16'd7, 16'd7, 4'd9, 64'h0, 1'b0, -1, -1);
    drain(50);
    chk("t3_nop_writes", wlog.size(), 0);
    chk("t3_nop_reads", rlog_n, 0);

    // response held 20 cycles while the FIFO fills behind it
    done_at = 2; rsp_ready = 0;
    push(8'h16, 16'd1, 16'd1, 16'd1, 4'd7, 64'hDEAD_BEEF_0000_0042, 1'b0, 2, 4);
    begin
      int n = 0;
      while (!rsp_valid && n < 100) begin @(posedge clk); #1; n++; end
    end
    chk("t4_rsp_held", rsp_valid, 1);
    snap_tag = rsp_tag; snap_sum = rsp_sum; snap_err = rsp_err; hold_bad = 0; hold_mon = 1;
    push(8'h15, 16'd2, 16'd2, 16'd2, 4'd0, 64'h0000_ABCD_0000_1111, 1'b0, 2, 4);
    push(8'h14, 16'd3, 16'd3, 16'd3, 4'd1, 64'h1234, 1'b0, 2, 4);
    push(8'h11, 16'd4, 16'd4, 16'd4, 4'd2, 64'h0, 1'b0, 2, 4);
    push(8'h16, 16'd5, 16'd5, 16'd5, 4'd3, 64'hDEAD_BEEF_0000_0042, 1'b0, 2, 4);
    chk("t4_q_full", q_count, 4);
    chk("t4_ready_low", cmd_ready, 0);
    cmd_valid = 1; cmd_op = 8'h14; cmd_tag = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 0;
    chk("t4_push_ignored", q_count, 4);
    repeat (14) @(posedge clk);
    #1;
    hold_mon = 0;
    chk("t4_hold_stable", hold_bad, 0);
    rsp_ready = 1;
    drain(400);
    repeat (10) @(posedge clk);
    #1;
    chk("t4_q_empty", q_count, 0);

    // status never reports done
    done_at = 0; rlog_n = 0;
    push(8'h11, 16'd0, 16'd0, 16'd0, 4'd5, 64'h0, 1'b1, 4096, 4097);
    drain(5000);
    chk("t5_no_sum_read", rlog_n, 0);

    // reset while polling abandons the command and the queue
    done_at = 0;
    push(8'h14, 16'd1, 16'd1, 16'd1, 4'd1, 64'h0, 1'b0, -1, -1);
    push(8'h15, 16'd1, 16'd1, 16'd1, 4'd2, 64'h0, 1'b0, -1, -1);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_q_before_rst", q_count, 1);
    chk("t6_polling", mmio_ren, 1);
    rst = 1;
    sb.delete();
    @(negedge clk);
    chk("t6_rst_strobes", {mmio_wen, mmio_ren}, 0);
    chk("t6_rst_addr", mmio_addr, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    chk("t6_rst_q_count", q_count, 0);
    chk("t6_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rst = 0;
    done_at = 3;
    push(8'h14, 16'd9, 16'd9, 16'd9, 4'd6, 64'h1234, 1'b0, 3, 5);
    drain(200);

    chk("mmio_protocol", proto_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
